// File: rtl/wb_arbiter_pkg.sv
// Shared Kestrel bus definitions: arbiter state encoding, bus widths and watchdog defaults.
package wb_arbiter_pkg;

  localparam int unsigned WbAdrW           = 15;
  localparam int unsigned WbDatW           = 16;
  localparam int unsigned WdogWidth        = 16;
  localparam int unsigned WbTimeoutDefault = 255;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } arb_state_e;

  // Grant state that belongs to a master index (0 or 1).
  function automatic arb_state_e grant_state(input logic master);
    return master ? StGnt1 : StGnt0;
  endfunction

endpackage

// File: rtl/wb_arbiter_watchdog.sv
// Stall watchdog: counts unacknowledged strobe cycles and flags the cycle that reaches the limit.
module wb_watchdog
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = WbTimeoutDefault
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_count,
  input  logic i_clear,
  output logic o_expire
);

  localparam logic [WdogWidth-1:0] LastCount = WdogWidth'(TIMEOUT - 1);
  localparam logic [WdogWidth-1:0] MaxCount  = '1;

  logic [WdogWidth-1:0] r_count;

  // The TIMEOUT-th stalled cycle expires; an ack in that cycle drops i_count, so ack wins.
  assign o_expire = i_count & (r_count == LastCount);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_count && (r_count != MaxCount)) begin
      r_count <= r_count + WdogWidth'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: alternating tie-break, locked cycles, direct hand-off and a
// stall watchdog that aborts a hung cycle and blocks the aborted master until it lets go.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = WbTimeoutDefault
) (
  input  logic              sys_clk_i,
  input  logic              sys_res_i,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [15:1]       m0_adr_i,
  input  logic [15:0]       m0_dat_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [15:0]       m0_dat_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [15:1]       m1_adr_i,
  input  logic [15:0]       m1_dat_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [15:0]       m1_dat_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [15:1]       s_adr_o,
  output logic [15:0]       s_dat_o,
  input  logic [15:0]       s_dat_i,
  input  logic              s_ack_i
);

  arb_state_e r_state;
  logic       r_last;   // 1: master 1 was granted most recently
  logic       r_blk0;
  logic       r_blk1;

  logic w_gnt0;
  logic w_gnt1;
  logic w_req0;
  logic w_req1;
  logic w_stall;
  logic w_clear;
  logic w_expire;

  assign w_gnt0 = (r_state == StGnt0);
  assign w_gnt1 = (r_state == StGnt1);

  // A master aborted by the watchdog is not eligible until its cyc has been low at an edge.
  assign w_req0 = m0_cyc_i & ~r_blk0;
  assign w_req1 = m1_cyc_i & ~r_blk1;

  assign s_cyc_o = w_gnt0 ? m0_cyc_i : (w_gnt1 ? m1_cyc_i : 1'b0);
  assign s_stb_o = w_gnt0 ? m0_stb_i : (w_gnt1 ? m1_stb_i : 1'b0);
  assign s_we_o  = w_gnt0 ? m0_we_i  : (w_gnt1 ? m1_we_i  : 1'b0);
  assign s_adr_o = w_gnt0 ? m0_adr_i : (w_gnt1 ? m1_adr_i : '0);
  assign s_dat_o = w_gnt0 ? m0_dat_i : (w_gnt1 ? m1_dat_i : '0);

  assign m0_ack_o = w_gnt0 & s_ack_i & m0_stb_i;
  assign m1_ack_o = w_gnt1 & s_ack_i & m1_stb_i;
  assign m0_err_o = w_gnt0 & w_expire;
  assign m1_err_o = w_gnt1 & w_expire;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign w_stall = s_cyc_o & s_stb_o & ~s_ack_i;
  assign w_clear = ~(s_cyc_o & s_stb_o) | s_ack_i;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (sys_clk_i),
    .i_rst_n  (sys_res_i),
    .i_count  (w_stall),
    .i_clear  (w_clear),
    .o_expire (w_expire)
  );

  always_ff @(posedge sys_clk_i or negedge sys_res_i) begin
    if (!sys_res_i) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
      r_blk0  <= 1'b0;
      r_blk1  <= 1'b0;
    end else begin
      if (!m0_cyc_i) r_blk0 <= 1'b0;
      if (!m1_cyc_i) r_blk1 <= 1'b0;

      case (r_state)
        StIdle: begin
          if (w_req0 && (!w_req1 || r_last)) begin
            r_state <= grant_state(1'b0);
            r_last  <= 1'b0;
          end else if (w_req1) begin
            r_state <= grant_state(1'b1);
            r_last  <= 1'b1;
          end
        end
        StGnt0: begin
          if (w_expire) begin
            r_state <= StIdle;
            r_blk0  <= 1'b1;
          end else if (!m0_cyc_i) begin
            if (w_req1) begin
              r_state <= StGnt1;
              r_last  <= 1'b1;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        StGnt1: begin
          if (w_expire) begin
            r_state <= StIdle;
            r_blk1  <= 1'b1;
          end else if (!m1_cyc_i) begin
            if (w_req0) begin
              r_state <= StGnt0;
              r_last  <= 1'b0;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run against a model.
module tb_wb_arbiter;

  localparam int Tmo = 8;
  localparam logic [14:0] A0 = 15'h1111;
  localparam logic [14:0] A1 = 15'h2222;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [14:0] m0_adr, m1_adr;
  logic [15:0] m0_wdat, m1_wdat;
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic [15:0] m0_rdat, m1_rdat;
  logic s_cyc, s_stb, s_we, s_ack;
  logic [14:0] s_adr;
  logic [15:0] s_wdat, s_rdat;
  logic [69:0] act;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  int md_owner;
  int md_last;
  int md_stall;
  bit md_blk[2];

  always #5 clk = ~clk;

  wb_arbiter #(
    .TIMEOUT (Tmo)
  ) dut (
    .sys_clk_i (clk),
    .sys_res_i (rst_n),
    .m0_cyc_i  (m0_cyc),
    .m0_stb_i  (m0_stb),
    .m0_we_i   (m0_we),
    .m0_adr_i  (m0_adr),
    .m0_dat_i  (m0_wdat),
    .m0_ack_o  (m0_ack),
    .m0_err_o  (m0_err),
    .m0_dat_o  (m0_rdat),
    .m1_cyc_i  (m1_cyc),
    .m1_stb_i  (m1_stb),
    .m1_we_i   (m1_we),
    .m1_adr_i  (m1_adr),
    .m1_dat_i  (m1_wdat),
    .m1_ack_o  (m1_ack),
    .m1_err_o  (m1_err),
    .m1_dat_o  (m1_rdat),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_wdat),
    .s_dat_i   (s_rdat),
    .s_ack_i   (s_ack)
  );

  assign act = {s_cyc, s_stb, s_we, s_adr, s_wdat, m0_ack, m0_err, m1_ack, m1_err,
                m0_rdat, m1_rdat};

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0;
    s_ack = 0; s_rdat = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = A0; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    #1;
    n_cmp++;
    if (act !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", act);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (act !== '0) begin
      n_fail++; $display("FAIL reset_held_over_edge: got %h expected 0", act);
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_tie_handoff();
    m0_cyc = 1; m0_stb = 1; m0_adr = A0;
    m1_cyc = 1; m1_stb = 1; m1_adr = A1;
    @(negedge clk);
    n_cmp++;
    if (s_cyc !== 1'b0) begin
      n_fail++; $display("FAIL tie_idle_first: s_cyc got %b expected 0", s_cyc);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_adr} !== {1'b1, A0}) begin
      n_fail++; $display("FAIL tie_m0_first: got cyc=%b adr=%h expected cyc=1 adr=%h",
                         s_cyc, s_adr, A0);
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_stb, s_adr} !== {1'b1, 1'b1, A1}) begin
      n_fail++; $display("FAIL handoff_m1: got cyc=%b stb=%b adr=%h expected 1 1 %h",
                         s_cyc, s_stb, s_adr, A1);
    end
    m1_cyc = 0; m1_stb = 0;
    step();
  endtask

  task automatic test_read();
    int acks = 0;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 15'h0200;
    step();
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin s_ack = 1; s_rdat = 16'h1234; end
      @(negedge clk);
      if (m1_ack) acks++;
      if (k == 3) begin
        n_cmp++;
        if ({m1_ack, m1_rdat, m0_ack, s_adr} !== {1'b1, 16'h1234, 1'b0, 15'h0200}) begin
          n_fail++; $display("FAIL read_ack: got ack=%b dat=%h m0ack=%b adr=%h expected 1 1234 0 0200",
                             m1_ack, m1_rdat, m0_ack, s_adr);
        end
      end
      step();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    if (m1_ack) acks++;
    n_cmp++;
    if (acks != 1) begin
      n_fail++; $display("FAIL read_ack_count: got %0d expected 1", acks);
    end
    step();
  endtask

  task automatic test_locked();
    int acks = 0;
    int bad = 0;
    m0_cyc = 1; m0_stb = 0; m0_adr = A0;
    m1_cyc = 1; m1_stb = 1; m1_adr = A1;
    step();
    for (int k = 0; k < 8; k++) begin
      m0_stb = (k % 2 == 0); s_ack = (k % 2 == 0);
      @(negedge clk);
      if (m0_ack) acks++;
      if (s_cyc !== 1'b1 || s_adr !== A0 || m1_ack !== 1'b0) bad++;
      step();
    end
    s_ack = 0; m0_stb = 0;
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL locked_hold: got %0d cycles off-grant expected 0", bad);
    end
    n_cmp++;
    if (acks != 4) begin
      n_fail++; $display("FAIL locked_acks: got %0d expected 4", acks);
    end
    m0_cyc = 0;
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_stb, s_adr} !== {1'b1, 1'b1, A1}) begin
      n_fail++; $display("FAIL locked_release_m1: got cyc=%b stb=%b adr=%h expected 1 1 %h",
                         s_cyc, s_stb, s_adr, A1);
    end
    m1_cyc = 0; m1_stb = 0;
    step();
  endtask

  task automatic test_timeout();
    int k = 0;
    bit got = 0;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = A0; m0_wdat = 16'hBEEF;
    m1_cyc = 1; m1_stb = 1; m1_adr = A1;
    step();
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (m0_err) got = 1;
      else step();
    end
    n_cmp++;
    if (!got || k != Tmo) begin
      n_fail++; $display("FAIL timeout_cycle: got err on stall %0d (seen=%0d) expected %0d",
                         k, got, Tmo);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_stb, m0_err, m1_ack} !== 4'b0000) begin
      n_fail++; $display("FAIL timeout_idle: got %b expected 0000", {s_cyc, s_stb, m0_err, m1_ack});
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_adr} !== {1'b1, A1}) begin
      n_fail++; $display("FAIL timeout_m1_next: got cyc=%b adr=%h expected 1 %h", s_cyc, s_adr, A1);
    end
    m1_cyc = 0; m1_stb = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      @(negedge clk);
      n_cmp++;
      if (s_cyc !== 1'b0) begin
        n_fail++; $display("FAIL timeout_m0_blocked: cycle %0d s_cyc got %b expected 0", j, s_cyc);
      end
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    m0_cyc = 1; m0_stb = 1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_adr} !== {1'b1, A0}) begin
      n_fail++; $display("FAIL timeout_m0_regrant: got cyc=%b adr=%h expected 1 %h", s_cyc, s_adr, A0);
    end
    m0_cyc = 0; m0_stb = 0;
    step();
  endtask

  task automatic test_ack_on_timeout();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = A0;
    step();
    for (int k = 1; k <= Tmo; k++) begin
      if (k == Tmo) s_ack = 1;
      @(negedge clk);
      n_cmp++;
      if ({m0_ack, m0_err} !== {(k == Tmo), 1'b0}) begin
        n_fail++; $display("FAIL ack_wins stall %0d: got ack=%b err=%b expected %b 0",
                           k, m0_ack, m0_err, (k == Tmo));
      end
      step();
      s_ack = 0;
    end
    for (int k = 1; k <= Tmo; k++) begin
      @(negedge clk);
      n_cmp++;
      if (m0_err !== (k == Tmo)) begin
        n_fail++; $display("FAIL counter_cleared stall %0d: got err=%b expected %b",
                           k, m0_err, (k == Tmo));
      end
      step();
    end
    m0_cyc = 0; m0_stb = 0;
    step();
  endtask

  task automatic test_async_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = A0; m0_wdat = 16'h5A5A;
    step();
    @(negedge clk);
    n_cmp++;
    if ({s_cyc, s_stb, s_we} !== 3'b111) begin
      n_fail++; $display("FAIL async_pre: got %b expected 111", {s_cyc, s_stb, s_we});
    end
    #2;
    rst_n = 0; s_ack = 1;
    #1;
    n_cmp++;
    if ({s_cyc, s_stb, m0_ack, m0_err} !== 4'b0000) begin
      n_fail++; $display("FAIL async_drop: got %b expected 0000", {s_cyc, s_stb, m0_ack, m0_err});
    end
    @(posedge clk);
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_random(input int n);
    int ack_pct = 40;
    int o;
    bit stalled, tmo;
    logic c[2], s[2], w[2];
    logic [14:0] a[2];
    logic [15:0] d[2];
    logic e_cyc, e_stb, e_we;
    logic [14:0] e_adr;
    logic [15:0] e_wdat;
    logic [1:0] e_ack, e_err;
    logic [69:0] exp;
    do_reset();
    md_owner = -1; md_last = 1; md_stall = 0; md_blk[0] = 0; md_blk[1] = 0;
    for (int i = 0; i < n; i++) begin
      if (i % 200 == 0) ack_pct = ((i / 200) % 3 == 0) ? 40 : (((i / 200) % 3 == 1) ? 0 : 10);
      if (m0_cyc) m0_cyc = ($urandom_range(7) != 0); else m0_cyc = ($urandom_range(3) == 0);
      if (m1_cyc) m1_cyc = ($urandom_range(7) != 0); else m1_cyc = ($urandom_range(3) == 0);
      m0_stb = m0_cyc & ($urandom_range(3) != 0);
      m1_stb = m1_cyc & ($urandom_range(3) != 0);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_adr = 15'($urandom); m1_adr = 15'($urandom);
      m0_wdat = 16'($urandom); m1_wdat = 16'($urandom);
      s_ack = ($urandom_range(99) < ack_pct);
      s_rdat = 16'($urandom);
      @(negedge clk);
      c[0] = m0_cyc; s[0] = m0_stb; w[0] = m0_we; a[0] = m0_adr; d[0] = m0_wdat;
      c[1] = m1_cyc; s[1] = m1_stb; w[1] = m1_we; a[1] = m1_adr; d[1] = m1_wdat;
      o = md_owner;
      e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_wdat = '0; e_ack = '0; e_err = '0;
      stalled = 0; tmo = 0;
      if (o >= 0) begin
        e_cyc = c[o]; e_stb = s[o]; e_we = w[o]; e_adr = a[o]; e_wdat = d[o];
        e_ack[o] = s_ack & s[o];
        stalled = c[o] && s[o] && !s_ack;
        tmo = stalled && (md_stall + 1 == Tmo);
        e_err[o] = tmo;
      end
      exp = {e_cyc, e_stb, e_we, e_adr, e_wdat, e_ack[0], e_err[0], e_ack[1], e_err[1],
             s_rdat, s_rdat};
      n_cmp++;
      if (act !== exp) begin
        n_fail++; $display("FAIL random cycle %0d: got %h expected %h", i, act, exp);
      end
      // Advance the model by the rules: grant, lock, hand-off, abort and block.
      if (o < 0) begin
        if (c[0] && !md_blk[0] && c[1] && !md_blk[1]) md_owner = 1 - md_last;
        else if (c[0] && !md_blk[0]) md_owner = 0;
        else if (c[1] && !md_blk[1]) md_owner = 1;
        if (md_owner >= 0) md_last = md_owner;
      end
      for (int m = 0; m < 2; m++) if (!c[m]) md_blk[m] = 0;
      if (o >= 0) begin
        if (tmo) begin
          md_blk[o] = 1; md_owner = -1;
        end else if (!c[o]) begin
          if (c[1-o] && !md_blk[1-o]) begin md_owner = 1 - o; md_last = 1 - o; end
          else md_owner = -1;
        end
      end
      md_stall = (stalled && !tmo) ? md_stall + 1 : 0;
      step();
    end
    clear_inputs();
    repeat (2) step();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1;
    test_reset();
    test_tie_handoff();
    test_read();
    test_locked();
    test_timeout();
    test_ack_on_timeout();
    test_async_reset();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, sets the number of consecutive unacknowledged strobe cycles before the arbiter aborts a bus cycle.
REQ-002 sys_clk_i  in  1  single clock; all state changes on its rising edge.
REQ-003 sys_res_i  in  1  reset; asynchronous and active-low.
REQ-004 m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (CPU) Wishbone cycle, strobe and write-enable.
REQ-005 m0_adr_i  in  15 [15:1]  master 0 word address; m0_dat_i  in  16  master 0 write data.
REQ-006 m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge and abort; m0_dat_o  out  16  master 0 read data.
REQ-007 m1_* ports are identical to m0_* ports and serve master 1 (video/DMA fetch).
REQ-008 s_cyc_o, s_stb_o, s_we_o  out  1 each  shared-slave cycle, strobe and write-enable.
REQ-009 s_adr_o  out  15 [15:1]  shared-slave address; s_dat_o  out  16  shared-slave write data.
REQ-010 s_dat_i  in  16  shared-slave read data; s_ack_i  in  1  shared-slave acknowledge.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GNT0 and GNT1, held in registers.
REQ-012 In IDLE with exactly one mN_cyc_i high, the FSM SHALL enter GNTN on the next edge.
REQ-013 In IDLE with both cyc inputs high, the FSM SHALL grant the master that is not recorded in the 1-bit last-grant register.
REQ-014 The last-grant register SHALL update on every entry into a GNT state.
REQ-015 In GNTN, s_cyc_o SHALL equal mN_cyc_i, and s_stb_o, s_we_o, s_adr_o and s_dat_o SHALL follow master N combinationally.
REQ-016 In GNTN, mN_ack_o SHALL equal s_ack_i AND mN_stb_i, and the other master's ack_o and err_o SHALL be 0.
REQ-017 Both mN_dat_o SHALL always carry s_dat_i; no read data is registered.
REQ-018 In IDLE, all s_* outputs SHALL be 0 and all ack_o and err_o outputs SHALL be 0.
REQ-019 The grant SHALL be held while mN_cyc_i is high, including across multiple strobes (locked cycle).
REQ-020 When the granted mN_cyc_i falls and the other master's cyc is high, the FSM SHALL hand off directly to the other GNT state on the same edge, with no IDLE cycle.
REQ-021 When the granted mN_cyc_i falls and the other master's cyc is low, the FSM SHALL return to IDLE.
REQ-022 A 16-bit watchdog counter SHALL increment each cycle that s_stb_o=1 and s_ack_i=0, and SHALL clear on any ack and on any cycle with s_stb_o=0.
REQ-023 When the watchdog reaches TIMEOUT, mN_err_o SHALL pulse for exactly one cycle, the FSM SHALL go to IDLE, and s_cyc_o and s_stb_o SHALL drop on the next edge.
REQ-024 After a timeout, the aborted master SHALL NOT be regranted until its cyc has been seen low for at least one cycle; the other master is not blocked by this.
REQ-025 If s_ack_i and the timeout coincide in the same cycle, the ack SHALL win: ack is delivered, no err is raised and the counter clears.

Reset
REQ-026 While sys_res_i=0, the FSM SHALL be IDLE, last-grant SHALL be 1 (so m0 wins the first tie), the watchdog SHALL be 0, the post-abort block flags SHALL be clear and all outputs SHALL be 0.
REQ-027 Reset asserted mid-cycle SHALL drop s_cyc_o and s_stb_o immediately (asynchronously), without generating ack or err.

Structure
REQ-028 State encodings and the TIMEOUT default SHALL live in the shared Kestrel bus-definitions include.
REQ-029 The watchdog SHALL be a sub-module named wb_watchdog (count, clear, expire); the rest of the logic is flat.

Verification
REQ-030 Scenario: reset, then m0 and m1 raise cyc on the same edge -> m0 granted first; after m0 drops cyc, m1 is granted on the same edge.
REQ-031 Scenario: m1 reads 0x1234 at 0x0400 with ack on the 3rd cycle -> m1_ack_o is high for 1 cycle, m1_dat_o=0x1234 and m0_ack_o stays 0.
REQ-032 Scenario: m0 locked cycle with 4 strobes while m1 requests -> m1 waits through all 4 strobes and is granted only after m0_cyc_i falls.
REQ-033 Scenario: TIMEOUT=8 and the slave never acks m0 -> m0_err_o pulses on the 8th stalled cycle, m1 is granted next, and m0 is blocked until its cyc toggles low.
REQ-034 Scenario: s_ack_i arrives on the exact timeout cycle -> ack is delivered, err stays 0 and the counter clears.
REQ-035 Scenario: sys_res_i pulled low mid-write -> s_cyc_o falls asynchronously before the next clock edge and no ack is delivered.
